// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the matrix functions engine.
// Owns the shared matrix store (A at BASE_A, B at BASE_B, C at BASE_C), serves
// zero-latency engine reads and single-cycle engine writes, streams operand
// matrices in from the host loader, and sweeps region C to zero on request.
// Ports:
//   clk, reset (async, active-low)
//   req_rd_en/req_wr_en/req_addr/req_wdata -> rsp_rdata : engine access
//   ld_start/ld_sel/ld_m/ld_n/ld_valid/ld_data -> ld_ready/load_done : loader
//   clr_start -> clr_done : region-C clear
//   A_m/A_n/B_m/B_n : committed dimensions; busy, dim_err, addr_err : status
module matrix_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 96,
  parameter int unsigned BASE_A     = 0,
  parameter int unsigned BASE_B     = 32,
  parameter int unsigned BASE_C     = 64,
  parameter int unsigned MAX_DIM    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rd_en,
  input  logic                  req_wr_en,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  input  logic                  ld_start,
  input  logic                  ld_sel,
  input  logic [3:0]            ld_m,
  input  logic [3:0]            ld_n,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  load_done,
  input  logic                  clr_start,
  output logic                  clr_done,
  output logic [3:0]            A_m,
  output logic [3:0]            A_n,
  output logic [3:0]            B_m,
  output logic [3:0]            B_n,
  output logic                  dim_err,
  output logic                  addr_err
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DIM_W  = 4;
  localparam int unsigned PROD_W = 8;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_A_A   = ADDR_WIDTH'(BASE_A);
  localparam logic [ADDR_WIDTH-1:0] BASE_B_A   = ADDR_WIDTH'(BASE_B);
  localparam logic [ADDR_WIDTH-1:0] BASE_C_A   = ADDR_WIDTH'(BASE_C);
  localparam logic [DIM_W-1:0]      MAX_DIM_D  = DIM_W'(MAX_DIM);
  localparam logic [CNT_W-1:0]      CLR_LAST   = CNT_W'(MAX_DIM * MAX_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [DIM_W-1:0] m_q, m_d, n_q, n_d;
  logic [DIM_W-1:0] a_m_q, a_m_d, a_n_q, a_n_d;
  logic [DIM_W-1:0] b_m_q, b_m_d, b_n_q, b_n_d;
  logic             busy_q, busy_d;
  logic             ld_ready_q, ld_ready_d;
  logic             load_done_q, load_done_d;
  logic             clr_done_q, clr_done_d;
  logic             dim_err_q, dim_err_d;
  logic             addr_err_q, addr_err_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  addr_ok;
  logic                  dim_bad;
  logic [PROD_W-1:0]     prod;
  logic                  load_last;
  logic [ADDR_WIDTH-1:0] load_base;

  assign addr_ok   = (req_addr < DEPTH_A);
  assign dim_bad   = (ld_m == '0) || (ld_n == '0) || (ld_m > MAX_DIM_D) || (ld_n > MAX_DIM_D);
  assign prod      = PROD_W'(m_q) * PROD_W'(n_q);
  assign load_last = (PROD_W'(cnt_q) == (prod - PROD_W'(1)));
  assign load_base = sel_q ? BASE_B_A : BASE_A_A;

  // Zero-latency engine read; the array is only exposed while idle.
  always_comb begin
    rsp_rdata = '0;
    if (req_rd_en && (state_q == ST_IDLE) && addr_ok) begin
      rsp_rdata = mem[req_addr];
    end
  end

  // Next-state, single write-port arbitration and registered status.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    m_d         = m_q;
    n_d         = n_q;
    a_m_d       = a_m_q;
    a_n_d       = a_n_q;
    b_m_d       = b_m_q;
    b_n_d       = b_n_q;
    load_done_d = 1'b0;
    clr_done_d  = 1'b0;
    dim_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = req_addr;
    mem_wdata   = req_wdata;
    // Sticky regardless of state; only reset clears it.
    addr_err_d  = addr_err_q | ((req_rd_en | req_wr_en) & ~addr_ok);

    unique case (state_q)
      ST_IDLE: begin
        mem_we = req_wr_en & addr_ok;
        if (ld_start) begin
          if (dim_bad) begin
            dim_err_d = 1'b1;
          end else begin
            sel_d = ld_sel;
            m_d   = ld_m;
            n_d   = ld_n;
            // Zeroed dimensions mark the target matrix invalid while it loads.
            if (ld_sel) begin
              b_m_d = '0;
              b_n_d = '0;
            end else begin
              a_m_d = '0;
              a_n_d = '0;
            end
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end else if (clr_start) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = load_base + ADDR_WIDTH'(cnt_q);
          mem_wdata = ld_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (load_last) begin
            if (sel_q) begin
              b_m_d = m_q;
              b_n_d = n_q;
            end else begin
              a_m_d = m_q;
              a_n_d = n_q;
            end
            load_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = BASE_C_A + ADDR_WIDTH'(cnt_q);
        mem_wdata = '0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CLR_LAST) begin
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    ld_ready_d = (state_d == ST_LOAD);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      m_q         <= '0;
      n_q         <= '0;
      a_m_q       <= '0;
      a_n_q       <= '0;
      b_m_q       <= '0;
      b_n_q       <= '0;
      busy_q      <= 1'b0;
      ld_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      clr_done_q  <= 1'b0;
      dim_err_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      m_q         <= m_d;
      n_q         <= n_d;
      a_m_q       <= a_m_d;
      a_n_q       <= a_n_d;
      b_m_q       <= b_m_d;
      b_n_q       <= b_n_d;
      busy_q      <= busy_d;
      ld_ready_q  <= ld_ready_d;
      load_done_q <= load_done_d;
      clr_done_q  <= clr_done_d;
      dim_err_q   <= dim_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy      = busy_q;
  assign ld_ready  = ld_ready_q;
  assign load_done = load_done_q;
  assign clr_done  = clr_done_q;
  assign dim_err   = dim_err_q;
  assign addr_err  = addr_err_q;
  assign A_m       = a_m_q;
  assign A_n       = a_n_q;
  assign B_m       = b_m_q;
  assign B_n       = b_n_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed self-checking bench for matrix_mem_responder.
module tb_matrix_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       req_rd_en, req_wr_en;
  logic [6:0] req_addr;
  logic [3:0] req_wdata, rsp_rdata;
  logic       busy;
  logic       ld_start, ld_sel;
  logic [3:0] ld_m, ld_n;
  logic       ld_valid;
  logic [3:0] ld_data;
  logic       ld_ready, load_done;
  logic       clr_start, clr_done;
  logic [3:0] a_m, a_n, b_m, b_n;
  logic       dim_err, addr_err;

  int total;
  int bad;

  matrix_mem_responder dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_rd_en (req_rd_en),
    .req_wr_en (req_wr_en),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ld_start  (ld_start),
    .ld_sel    (ld_sel),
    .ld_m      (ld_m),
    .ld_n      (ld_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .load_done (load_done),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .A_m       (a_m),
    .A_n       (a_n),
    .B_m       (b_m),
    .B_n       (b_n),
    .dim_err   (dim_err),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_rd_en = 0; req_wr_en = 0; req_addr = '0; req_wdata = '0;
    ld_start = 0; ld_sel = 0; ld_m = '0; ld_n = '0; ld_valid = 0; ld_data = '0;
    clr_start = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, ld_ready, load_done, clr_done, dim_err, addr_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {busy, ld_ready, load_done, clr_done, dim_err, addr_err});
    end
    total++;
    if ({a_m, a_n, b_m, b_n} !== 16'h0) begin
      bad++;
      $display("FAIL reset_dims got=%h want=0000", {a_m, a_n, b_m, b_n});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_a();
    ld_start = 1; ld_sel = 0; ld_m = 4'd2; ld_n = 4'd3;
    tick();
    ld_start = 0;
    total++;
    if ({busy, ld_ready, a_m, a_n} !== {2'b11, 8'h00}) begin
      bad++;
      $display("FAIL load_a_enter got busy=%b rdy=%b A=%0d,%0d want 1 1 0,0", busy, ld_ready, a_m, a_n);
    end
    for (int i = 1; i <= 6; i++) begin
      ld_valid = 1; ld_data = 4'(i);
      tick();
      if (i == 5) begin
        total++;
        if ({load_done, a_m, a_n} !== 9'h0) begin
          bad++;
          $display("FAIL load_a_mid got done=%b A=%0d,%0d want 0 0,0", load_done, a_m, a_n);
        end
      end
    end
    ld_valid = 0;
    total++;
    if ({load_done, busy, a_m, a_n} !== {2'b10, 4'd2, 4'd3}) begin
      bad++;
      $display("FAIL load_a_done got done=%b busy=%b A=%0d,%0d want 1 0 2,3", load_done, busy, a_m, a_n);
    end
    tick();
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL load_a_pulse got=%b want=0", load_done);
    end
    req_rd_en = 1;
    for (int i = 0; i < 6; i++) begin
      req_addr = 7'(i);
      #1;
      total++;
      if (rsp_rdata !== 4'(i + 1)) begin
        bad++;
        $display("FAIL load_a_read addr=%0d got=%0d want=%0d", i, rsp_rdata, i + 1);
      end
    end
    req_rd_en = 0;
  endtask

  task automatic test_load_b_gaps();
    int pulses;
    pulses = 0;
    ld_start = 1; ld_sel = 1; ld_m = 4'd3; ld_n = 4'd2;
    tick();
    ld_start = 0;
    for (int k = 0; k < 14; k++) begin
      ld_valid = (k % 2 == 0);
      ld_data  = 4'(7 + k / 2);
      tick();
      if (load_done) pulses++;
    end
    ld_valid = 0;
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL load_b_pulses got=%0d want=1", pulses);
    end
    total++;
    if ({b_m, b_n, a_m, a_n} !== {4'd3, 4'd2, 4'd2, 4'd3}) begin
      bad++;
      $display("FAIL load_b_dims got B=%0d,%0d A=%0d,%0d want 3,2 2,3", b_m, b_n, a_m, a_n);
    end
    req_rd_en = 1;
    for (int i = 0; i < 6; i++) begin
      req_addr = 7'(32 + i);
      #1;
      total++;
      if (rsp_rdata !== 4'(7 + i)) begin
        bad++;
        $display("FAIL load_b_read addr=%0d got=%0d want=%0d", 32 + i, rsp_rdata, 7 + i);
      end
    end
    req_rd_en = 0;
  endtask

  task automatic test_dim_err();
    ld_start = 1; ld_sel = 0; ld_m = 4'd6; ld_n = 4'd2;
    tick();
    ld_start = 0;
    total++;
    if ({dim_err, busy, ld_ready} !== 3'b100) begin
      bad++;
      $display("FAIL dim_err_set got err=%b busy=%b rdy=%b want 1 0 0", dim_err, busy, ld_ready);
    end
    tick();
    total++;
    if ({dim_err, busy, a_m, a_n, b_m, b_n} !== {2'b00, 4'd2, 4'd3, 4'd3, 4'd2}) begin
      bad++;
      $display("FAIL dim_err_after got err=%b busy=%b A=%0d,%0d B=%0d,%0d", dim_err, busy, a_m, a_n, b_m, b_n);
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    int done_pulses;
    for (int a = 64; a <= 88; a++) begin
      req_wr_en = 1; req_addr = 7'(a); req_wdata = 4'hF;
      tick();
    end
    req_wr_en = 0;
    req_rd_en = 1; req_addr = 7'd88;
    #1;
    total++;
    if (rsp_rdata !== 4'hF) begin
      bad++;
      $display("FAIL clear_preload got=%h want=f", rsp_rdata);
    end
    req_rd_en = 0;
    clr_start = 1;
    tick();
    clr_start = 0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cycles++;
      if (k == 0) begin
        req_wr_en = 1; req_addr = 7'd5; req_wdata = 4'hA;
      end else begin
        req_wr_en = 0;
      end
      tick();
      if (clr_done) done_pulses++;
    end
    total++;
    if (busy_cycles != 25) begin
      bad++;
      $display("FAIL clear_busy_cycles got=%0d want=25", busy_cycles);
    end
    total++;
    if (done_pulses != 1) begin
      bad++;
      $display("FAIL clear_done_pulses got=%0d want=1", done_pulses);
    end
    req_rd_en = 1;
    for (int a = 64; a <= 88; a++) begin
      req_addr = 7'(a);
      #1;
      total++;
      if (rsp_rdata !== 4'h0) begin
        bad++;
        $display("FAIL clear_read addr=%0d got=%h want=0", a, rsp_rdata);
      end
    end
    req_addr = 7'd5;
    #1;
    total++;
    if (rsp_rdata !== 4'd6) begin
      bad++;
      $display("FAIL clear_drop_write got=%0d want=6", rsp_rdata);
    end
    req_rd_en = 0;
  endtask

  task automatic test_rw_and_range();
    req_rd_en = 1; req_wr_en = 1; req_addr = 7'd70; req_wdata = 4'd9;
    #1;
    total++;
    if (rsp_rdata !== 4'd0) begin
      bad++;
      $display("FAIL rw_old_value got=%0d want=0", rsp_rdata);
    end
    tick();
    req_wr_en = 0;
    #1;
    total++;
    if (rsp_rdata !== 4'd9) begin
      bad++;
      $display("FAIL rw_new_value got=%0d want=9", rsp_rdata);
    end
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL addr_err_clean got=%b want=0", addr_err);
    end
    req_addr = 7'd100;
    #1;
    total++;
    if (rsp_rdata !== 4'd0) begin
      bad++;
      $display("FAIL oor_read got=%0d want=0", rsp_rdata);
    end
    tick();
    req_rd_en = 0; req_addr = 7'd0;
    tick();
    tick();
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL addr_err_sticky got=%b want=1", addr_err);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1; ld_sel = 0; ld_m = 4'd2; ld_n = 4'd3;
    tick();
    ld_start = 0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = 4'(11 + i);
      tick();
    end
    ld_valid = 0;
    rst_n = 0;
    #2;
    total++;
    if ({a_m, a_n, b_m, b_n, ld_ready, busy, addr_err} !== 19'h0) begin
      bad++;
      $display("FAIL midload_reset got A=%0d,%0d B=%0d,%0d rdy=%b busy=%b aerr=%b",
               a_m, a_n, b_m, b_n, ld_ready, busy, addr_err);
    end
    tick();
    rst_n = 1;
    tick();
    ld_start = 1; ld_sel = 0; ld_m = 4'd1; ld_n = 4'd2;
    tick();
    ld_start = 0;
    ld_valid = 1; ld_data = 4'd14;
    tick();
    ld_data = 4'd15;
    tick();
    ld_valid = 0;
    total++;
    if ({load_done, busy, a_m, a_n, b_m, b_n} !== {2'b10, 4'd1, 4'd2, 8'h00}) begin
      bad++;
      $display("FAIL reload_done got done=%b busy=%b A=%0d,%0d B=%0d,%0d", load_done, busy, a_m, a_n, b_m, b_n);
    end
    req_rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 7'(i);
      #1;
      total++;
      if (rsp_rdata !== 4'(14 + i - ((i == 2) ? 3 : 0))) begin
        bad++;
        $display("FAIL reload_read addr=%0d got=%0d", i, rsp_rdata);
      end
    end
    req_rd_en = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_a();
    test_load_b_gaps();
    test_dim_err();
    test_clear();
    test_rw_and_range();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
